// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receiver.
package spi_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01
   } spi_state_t;

   // SPI mode encodings as {CKP, CPH}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchroniser with optional rise/fall pulse detection on the synced value.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter bit          EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], din};
   end

   assign q = chain[STAGES-1];

   generate
      if (EDGE_EN) begin : g_edge
         logic q_d;

         always_ff @(posedge clk) begin
            if (rst) q_d <= 1'b0;
            else     q_d <= q;
         end

         assign rise_c = q & ~q_d;
         assign fall_c = ~q & q_d;
      end else begin : g_no_edge
         assign rise_c = 1'b0;
         assign fall_c = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/receiver_spi.sv
// SPI slave: oversampled SCK/CS/MOSI, MSB-first deserialiser with valid/ready output and MISO return path.
// Optional macro SPI_RX_OVERRUN_EN: drop words that arrive while the previous one is unconsumed and flag overrun.
module receiver_spi
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              SCK,
   input  logic              CS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam int unsigned RSH_W = DATA_W - 1;

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_level_unused, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sck (
      .clk(clk), .rst(rst), .din(SCK),
      .q(sck_level_unused), .rise_c(sck_rise), .fall_c(sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_cs (
      .clk(clk), .rst(rst), .din(CS),
      .q(cs_level_unused), .rise_c(cs_rise), .fall_c(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .din(MOSI),
      .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
   );

   spi_state_t        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [RSH_W-1:0]  rsh_q, rsh_d;
   logic              miso_q, miso_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;

   logic samp_c, shft_c, done_c, accept_c, drop_c;

   // Sample/shift edge selection from the mode latched at CS fall
   always_comb begin
      samp_c = 1'b0;
      shft_c = 1'b0;
      case (mode_q)
         MODE0: begin samp_c = sck_rise; shft_c = sck_fall; end
         MODE1: begin samp_c = sck_fall; shft_c = sck_rise; end
         MODE2: begin samp_c = sck_fall; shft_c = sck_rise; end
         MODE3: begin samp_c = sck_rise; shft_c = sck_fall; end
      endcase
   end

   assign accept_c = rx_valid_q & rx_ready;
   assign done_c   = (state_q == ACTIVE) & ~cs_rise & ~shft_c & samp_c &
                     (bit_cnt_q == CNT_W'(DATA_W - 1));

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      bit_cnt_d  = bit_cnt_q;
      sreg_d     = sreg_q;
      rsh_d      = rsh_q;
      miso_d     = miso_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;

      if (accept_c) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = ACTIVE;
               mode_d    = {CKP, CPH};
               bit_cnt_d = '0;
               if (!CPH) begin
                  miso_d = tx_data[DATA_W-1];
                  sreg_d = tx_data << 1;
               end else begin
                  sreg_d = tx_data;
               end
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d   = IDLE;
               miso_d    = 1'b0;
               bit_cnt_d = '0;
            end else if (shft_c) begin
               miso_d = sreg_q[DATA_W-1];
               sreg_d = sreg_q << 1;
            end else if (samp_c) begin
               rsh_d = RSH_W'({rsh_q, mosi_s});
               if (done_c) begin
                  bit_cnt_d = '0;
                  sreg_d    = tx_data;
                  if (!drop_c) begin
                     rx_data_d  = {rsh_q, mosi_s};
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE0;
         bit_cnt_q  <= '0;
         sreg_q     <= '0;
         rsh_q      <= '0;
         miso_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         bit_cnt_q  <= bit_cnt_d;
         sreg_q     <= sreg_d;
         rsh_q      <= rsh_d;
         miso_q     <= miso_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

`ifdef SPI_RX_OVERRUN_EN
   logic ovr_q;

   assign drop_c = rx_valid_q & ~rx_ready;

   // Sticky until the held word is finally consumed
   always_ff @(posedge clk) begin
      if (rst)                  ovr_q <= 1'b0;
      else if (accept_c)        ovr_q <= 1'b0;
      else if (done_c & drop_c) ovr_q <= 1'b1;
   end

   assign overrun = ovr_q;
`else
   assign drop_c  = 1'b0;
   assign overrun = 1'b0;
`endif

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule
